cdb_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the common data bus (CDB). Each functional unit (FU) raises a request carrying the ROB tag of its completed result. The arbiter grants at most one FU per cycle and registers the winning FU index and tag. In the next cycle it drives `select_flag`, `select_signal` and `ROB_tag` of `common_data_bus`, so the chosen result is broadcast to the ROB and the reservation stations.

---
 rtl/cdb_arbiter.sv | 110 +++++++++++
 tb/tb_cdb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one completed FU result
// per cycle and broadcasts its index and ROB tag one cycle later.
module cdb_arbiter #(
  parameter int FU_NUM      = 4,
  parameter int ROB_TAG_LEN = 6,
  parameter int SEL_W       = $clog2(FU_NUM)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  flush,
  input  logic [FU_NUM-1:0]                     fu_req,
  input  logic [FU_NUM-1:0][ROB_TAG_LEN-1:0]    fu_rob_tag,
  output logic [FU_NUM-1:0]                     fu_grant,
  output logic                                  select_flag,
  output logic [SEL_W-1:0]                      select_signal,
  output logic [ROB_TAG_LEN-1:0]                ROB_tag,
  output logic [SEL_W-1:0]                      rr_ptr
);

  // One extra bit so rr_ptr + offset never overflows before the wrap compare.
  localparam logic [SEL_W:0]   FU_NUM_W = (SEL_W+1)'(FU_NUM);
  localparam logic [SEL_W-1:0] LAST_FU  = SEL_W'(FU_NUM - 1);

  logic                   found_s;
  logic [SEL_W-1:0]       win_s;
  logic [SEL_W:0]         idx_s;
  logic                   grant_vld_s;

  logic                   select_flag_q,   select_flag_d;
  logic [SEL_W-1:0]       select_signal_q, select_signal_d;
  logic [ROB_TAG_LEN-1:0] rob_tag_q,       rob_tag_d;
  logic [SEL_W-1:0]       rr_ptr_q,        rr_ptr_d;

  // Circular priority search starting at rr_ptr; first requester wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx_s = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      if (idx_s >= FU_NUM_W) begin
        idx_s = idx_s - FU_NUM_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && fu_req[idx_s[SEL_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[SEL_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant is suppressed by flush and held off entirely while in reset.
  always_comb begin
    grant_vld_s = found_s && !flush && reset_n;
    fu_grant    = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (grant_vld_s && (win_s == SEL_W'(i))) begin
        fu_grant[i] = 1'b1;
      end else begin
        fu_grant[i] = 1'b0;
      end
    end
  end

  // Next-state for the broadcast register and the round-robin pointer.
  always_comb begin
    select_flag_d   = 1'b0;
    select_signal_d = '0;
    rob_tag_d       = '0;
    rr_ptr_d        = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (grant_vld_s) begin
      select_flag_d   = 1'b1;
      select_signal_d = win_s;
      rob_tag_d       = fu_rob_tag[win_s];
      if (win_s == LAST_FU) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_s + SEL_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset drops any broadcast in flight immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      select_flag_q   <= 1'b0;
      select_signal_q <= '0;
      rob_tag_q       <= '0;
      rr_ptr_q        <= '0;
    end else begin
      select_flag_q   <= select_flag_d;
      select_signal_q <= select_signal_d;
      rob_tag_q       <= rob_tag_d;
      rr_ptr_q        <= rr_ptr_d;
    end
  end

  assign select_flag   = select_flag_q;
  assign select_signal = select_signal_q;
  assign ROB_tag       = rob_tag_q;
  assign rr_ptr        = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 4-FU instance driven cycle by cycle
// against a reference model, plus a 3-FU instance for the non-power-of-two case.
module tb_cdb_arbiter;

  typedef struct {
    logic       flag;
    logic [1:0] sel;
    logic [5:0] tag;
  } bc_t;

  logic             clock;
  logic             reset_n;
  logic             flush;
  logic [3:0]       fu_req;
  logic [3:0][5:0]  fu_rob_tag;
  logic [3:0]       fu_grant;
  logic             select_flag;
  logic [1:0]       select_signal;
  logic [5:0]       ROB_tag;
  logic [1:0]       rr_ptr;

  logic [2:0]       fu_req3;
  logic [2:0][5:0]  fu_rob_tag3;
  logic [2:0]       fu_grant3;
  logic             select_flag3;
  logic [1:0]       select_signal3;
  logic [5:0]       ROB_tag3;
  logic [1:0]       rr_ptr3;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  m_ptr    = 0;
  int  tag_ref [4] = '{5, 6, 7, 8};
  bc_t sb [$];

  cdb_arbiter #(.FU_NUM(4), .ROB_TAG_LEN(6)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .fu_req(fu_req), .fu_rob_tag(fu_rob_tag), .fu_grant(fu_grant),
    .select_flag(select_flag), .select_signal(select_signal),
    .ROB_tag(ROB_tag), .rr_ptr(rr_ptr)
  );

  cdb_arbiter #(.FU_NUM(3), .ROB_TAG_LEN(6)) dut3 (
    .clock(clock), .reset_n(reset_n), .flush(1'b0),
    .fu_req(fu_req3), .fu_rob_tag(fu_rob_tag3), .fu_grant(fu_grant3),
    .select_flag(select_flag3), .select_signal(select_signal3),
    .ROB_tag(ROB_tag3), .rr_ptr(rr_ptr3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_tags();
    for (int i = 0; i < 4; i++) fu_rob_tag[i] = 6'(tag_ref[i]);
  endtask

  // Called away from the clock edge: drive, check last broadcast and this grant, advance one edge.
  task automatic step(input logic [3:0] req, input logic fl);
    bc_t e;
    int w;
    logic [3:0] g;
    fu_req = req;
    flush  = fl;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("select_flag", 32'(select_flag), 32'(e.flag));
      check_eq("select_signal", 32'(select_signal), 32'(e.sel));
      check_eq("ROB_tag", 32'(ROB_tag), 32'(e.tag));
    end
    check_eq("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    w = -1;
    if (!fl) begin
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
    end
    g = (w >= 0) ? 4'(1 << w) : 4'b0000;
    check_eq("fu_grant", 32'(fu_grant), 32'(g));
    if (w >= 0) begin
      e.flag = 1'b1;
      e.sel  = 2'(w);
      e.tag  = 6'(tag_ref[w]);
      m_ptr  = (w + 1) % 4;
    end else begin
      e.flag = 1'b0;
      e.sel  = 2'b00;
      e.tag  = 6'd0;
      if (fl) m_ptr = 0;
    end
    sb.push_back(e);
    @(posedge clock);
    #2;
  endtask

  int g3 [4] = '{0, 1, 2, 0};
  int p3 [4] = '{1, 2, 0, 1};

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    fu_req  = 4'b1111;
    fu_req3 = 3'b000;
    set_tags();
    for (int i = 0; i < 3; i++) fu_rob_tag3[i] = 6'(10 + i);
    #12;
    check_eq("rst_grant", 32'(fu_grant), 32'd0);
    check_eq("rst_flag", 32'(select_flag), 32'd0);
    check_eq("rst_ptr", 32'(rr_ptr), 32'd0);
    check_eq("rst_tag", 32'(ROB_tag), 32'd0);
    check_eq("rst_sel", 32'(select_signal), 32'd0);
    reset_n = 1'b1;

    // Round-robin with all four requesting.
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b0);
    check_eq("rr_tag_last", 32'(ROB_tag), 32'd8);

    // Wrap and skip: FU2 moves pointer to 3, then 0011 grants FU0.
    step(4'b0100, 1'b0);
    check_eq("wrap_ptr3", 32'(rr_ptr), 32'd3);
    step(4'b0011, 1'b0);
    check_eq("wrap_ptr1", 32'(rr_ptr), 32'd1);
    step(4'b0010, 1'b0);
    check_eq("skip_ptr2", 32'(rr_ptr), 32'd2);

    // Flush one cycle after a grant to FU2.
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b1);
    check_eq("flush_ptr", 32'(rr_ptr), 32'd0);
    check_eq("flush_flag", 32'(select_flag), 32'd0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Single requester granted every cycle.
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b0);

    // X tag on a losing FU must not reach the bus.
    fu_rob_tag[0] = 6'bxxxxxx;
    fu_rob_tag[3] = 6'bxxxxxx;
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    set_tags();

    // Asynchronous reset mid-broadcast.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check_eq("pre_rst_flag", 32'(select_flag), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_flag", 32'(select_flag), 32'd0);
    check_eq("arst_tag", 32'(ROB_tag), 32'd0);
    check_eq("arst_ptr", 32'(rr_ptr), 32'd0);
    check_eq("arst_grant", 32'(fu_grant), 32'd0);
    sb.delete();
    m_ptr = 0;
    #1;
    reset_n = 1'b1;
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Three-FU instance, all requesting.
    fu_req3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("nf3_grant", 32'(fu_grant3), 32'(1 << g3[c]));
      @(posedge clock);
      #2;
      check_eq("nf3_ptr", 32'(rr_ptr3), 32'(p3[c]));
      check_eq("nf3_sel", 32'(select_signal3), 32'(g3[c]));
      check_eq("nf3_tag", 32'(ROB_tag3), 32'(10 + g3[c]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
